// File: rtl/aik2bin_acc.sv
// aik2bin_acc: serial Aiken (2421) decimal-string decoder and accumulator.
// Takes one 4-bit Aiken digit per handshake, most significant digit first.
// It decodes and validity-checks each digit and accumulates the binary value
// of the frame. One result per frame is handed downstream over valid/ready.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   in_digit/in_last are valid
//   in_ready   block can accept a digit this cycle (low while a result is held)
//   in_digit   Aiken-coded digit, MSD first
//   in_last    marks the final digit of the frame
//   out_valid  result available
//   out_ready  downstream accepts the result
//   out_bin    binary value of the frame (0 when out_err != 0)
//   out_ndig   digits accepted in the frame, saturates at 15
//   out_err    bit0: invalid Aiken code seen; bit1: length or overflow error
module aik2bin_acc #(
  parameter int NDIG  = 4,
  parameter int OUT_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_digit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_bin,
  output logic [3:0]       out_ndig,
  output logic [1:0]       out_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WW = OUT_W + 4;
  localparam logic [WW-1:0] TEN = WW'(10);

  // Aiken decode: returns {invalid, value}. Codes 0101..1010 are unused in
  // 2421 and decode as an invalid digit with value 0.
  function automatic logic [4:0] aiken_decode(input logic [3:0] code);
    logic [4:0] res;
    if (code <= 4'd4) begin
      res = {1'b0, code};
    end else if (code >= 4'd11) begin
      res = {1'b0, code - 4'd6};
    end else begin
      res = {1'b1, 4'd0};
    end
    return res;
  endfunction

  state_t          state;
  state_t          next_state;
  logic [OUT_W-1:0] acc;
  logic [3:0]      cnt;
  logic [1:0]      err;

  logic            accept;
  logic [4:0]      dec;
  logic [WW-1:0]   prod;
  logic            ovf;
  logic            len_err;
  logic [3:0]      new_cnt;
  logic [1:0]      new_err;

  assign in_ready = (state != DONE);
  assign accept   = in_valid & in_ready;

  // Decode the incoming digit and form the next accumulator, count and flags.
  always_comb begin
    dec     = aiken_decode(in_digit);
    prod    = ({4'b0000, acc} * TEN) + WW'(dec[3:0]);
    // anything above the low OUT_W bits means the value no longer fits
    ovf     = |prod[WW-1:OUT_W];
    len_err = (cnt == 4'(NDIG));
    if (cnt == 4'd15) begin
      new_cnt = 4'd15;
    end else begin
      new_cnt = cnt + 4'd1;
    end
    new_err = err | {(ovf | len_err), dec[4]};
  end

  // Next-state logic for the frame FSM.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, ACC: begin
        if (accept) begin
          if (in_last) begin
            next_state = DONE;
          end else begin
            next_state = ACC;
          end
        end else begin
          next_state = state;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_state = IDLE;
        end else begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Accumulator, flags and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= 4'd0;
      err       <= 2'b00;
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_ndig  <= 4'd0;
      out_err   <= 2'b00;
    end else if (accept) begin
      acc <= prod[OUT_W-1:0];
      cnt <= new_cnt;
      err <= new_err;
      if (in_last) begin
        out_valid <= 1'b1;
        out_bin   <= (new_err != 2'b00) ? '0 : prod[OUT_W-1:0];
        out_ndig  <= new_cnt;
        out_err   <= new_err;
      end
    end else if ((state == DONE) && out_ready) begin
      // result transfers this cycle; stale out_bin/ndig/err may remain
      out_valid <= 1'b0;
      acc       <= '0;
      cnt       <= 4'd0;
      err       <= 2'b00;
    end
  end

endmodule

// File: tb/tb_aik2bin_acc.sv
// tb_aik2bin_acc: directed self-checking bench for aik2bin_acc.
// Two instances share the input stimulus: one with default parameters and
// one with OUT_W=7 to reach the overflow path.
module tb_aik2bin_acc;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_digit;
  logic        in_last;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [13:0] out_bin;
  logic [3:0]  out_ndig;
  logic [1:0]  out_err;

  logic        in_ready7;
  logic        out_valid7;
  logic [6:0]  out_bin7;
  logic [3:0]  out_ndig7;
  logic [1:0]  out_err7;

  int n_cmp;
  int n_bad;

  aik2bin_acc #(.NDIG(4), .OUT_W(14)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_digit(in_digit), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_ndig(out_ndig), .out_err(out_err)
  );

  aik2bin_acc #(.NDIG(4), .OUT_W(7)) dut7 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready7),
    .in_digit(in_digit), .in_last(in_last),
    .out_valid(out_valid7), .out_ready(out_ready),
    .out_bin(out_bin7), .out_ndig(out_ndig7), .out_err(out_err7)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle 1 unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one digit for exactly one cycle.
  task automatic send(input logic [3:0] d, input logic last);
    in_valid = 1'b1;
    in_digit = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Let downstream take the held result.
  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_digit  = 4'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    check("rst_valid", out_valid, 0);
    check("rst_bin",   out_bin,   0);
    check("rst_ndig",  out_ndig,  0);
    check("rst_err",   out_err,   0);
    check("rst_ready", in_ready,  1);

    // 1: 7,4,9 -> 749, held until out_ready
    send(4'b1101, 1'b0);
    send(4'b0100, 1'b0);
    send(4'b1111, 1'b1);
    check("t1_valid", out_valid, 1);
    check("t1_bin",   out_bin,   749);
    check("t1_ndig",  out_ndig,  3);
    check("t1_err",   out_err,   0);
    check("t1_ready", in_ready,  0);
    tick();
    check("t1_hold_valid", out_valid, 1);
    check("t1_hold_ready", in_ready,  0);
    drain();
    check("t1_post_valid", out_valid, 0);
    check("t1_post_ready", in_ready,  1);

    // 2: single digit, out_ready tied high
    out_ready = 1'b1;
    send(4'b1011, 1'b1);
    check("t2_valid", out_valid, 1);
    check("t2_bin",   out_bin,   5);
    check("t2_ndig",  out_ndig,  1);
    check("t2_err",   out_err,   0);
    tick();
    check("t2_valid_one", out_valid, 0);
    check("t2_ready",     in_ready,  1);
    out_ready = 1'b0;

    // 3: invalid code forces 0 and err=01; next frame clean
    send(4'b0001, 1'b0);
    send(4'b0110, 1'b0);
    send(4'b0010, 1'b1);
    check("t3_bin",  out_bin,  0);
    check("t3_ndig", out_ndig, 3);
    check("t3_err",  out_err,  1);
    drain();
    send(4'b0010, 1'b1);
    check("t3b_bin", out_bin, 2);
    check("t3b_err", out_err, 0);
    drain();

    // 4a: five digits with NDIG=4 -> length error
    for (int i = 0; i < 4; i++) send(4'b1111, 1'b0);
    send(4'b1111, 1'b1);
    check("t4_bin",  out_bin,  0);
    check("t4_ndig", out_ndig, 5);
    check("t4_err",  out_err,  2);
    drain();

    // 4b: 127 fits in 7 bits
    send(4'b0001, 1'b0);
    send(4'b0010, 1'b0);
    send(4'b1101, 1'b1);
    check("t4_127_bin7", out_bin7, 127);
    check("t4_127_err7", out_err7, 0);
    check("t4_127_bin",  out_bin,  127);
    drain();
    // 128 overflows 7 bits but not 14
    send(4'b0001, 1'b0);
    send(4'b0010, 1'b0);
    send(4'b1110, 1'b1);
    check("t4_128_err7", out_err7, 2);
    check("t4_128_bin7", out_bin7, 0);
    check("t4_128_bin",  out_bin,  128);
    check("t4_128_err",  out_err,  0);
    drain();

    // 5: backpressure, pending digit not consumed while DONE
    send(4'b0011, 1'b1);
    in_valid = 1'b1;
    in_digit = 4'b0100;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_hold_valid", out_valid, 1);
      check("t5_hold_bin",   out_bin,   3);
      check("t5_hold_ready", in_ready,  0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t5_rel_valid", out_valid, 0);
    check("t5_rel_ready", in_ready,  1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("t5_next_valid", out_valid, 1);
    check("t5_next_bin",   out_bin,   4);
    check("t5_next_ndig",  out_ndig,  1);
    drain();

    // 6: gap then reset mid-frame discards it
    send(4'b0010, 1'b0);
    tick();
    tick();
    send(4'b0001, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_bin",   out_bin,   0);
    check("t6_rst_ndig",  out_ndig,  0);
    check("t6_rst_err",   out_err,   0);
    check("t6_rst_ready", in_ready,  1);
    tick();
    check("t6_idle_valid", out_valid, 0);
    send(4'b0011, 1'b1);
    check("t6_bin",  out_bin,  3);
    check("t6_ndig", out_ndig, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aik2bin_acc.md
Name: aik2bin_acc

Overview:
Serial Aiken (2421) decimal-string decoder and accumulator. It accepts one 4-bit Aiken-coded digit per handshake, most significant digit first, with a last-digit marker. It decodes each digit, checks code validity, and accumulates the binary value of the whole decimal number. It sits at the receive end of Aiken-coded digit streams and hands one binary result per frame to downstream logic over a valid/ready handshake.

Parameters:
NDIG, 4, maximum number of digits per frame (1..15)
OUT_W, 14, width of binary result; overflow beyond 2^OUT_W-1 is flagged

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_digit/in_last are valid
in_ready  output  1  block can accept a digit this cycle
in_digit  input  4  Aiken-coded digit, MSD first
in_last  input  1  marks final digit of frame
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_bin  output  OUT_W  binary value of frame (0 when out_err != 0)
out_ndig  output  4  digits accepted in frame, saturates at 15
out_err  output  2  bit0: invalid Aiken code seen; bit1: length or overflow error

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset, sampled on a clk edge:
  - state=IDLE; acc, cnt and err cleared.
  - out_valid=0, out_bin=0, out_ndig=0, out_err=0, in_ready=1.
  - Reset mid-frame or while holding a result discards it without emitting.
- States: IDLE (no digit yet), ACC (frame in progress), DONE (result held).
- in_ready=1 in IDLE and ACC; in_ready=0 in DONE.
- Digit accepted on a cycle where in_valid & in_ready.
- Decode:
  - 0000..0100 -> 0..4.
  - 1011..1111 -> 5..9 (code minus 6).
  - 0101..1010 -> invalid: set err[0]; digit treated as 0.
- On accept:
  - acc <= acc*10 + d, computed at OUT_W+4 bits.
  - If the result exceeds 2^OUT_W-1, set err[1]; acc keeps its low OUT_W bits, which do not matter because out_bin is forced to 0.
  - cnt <= cnt+1, saturating at 15.
  - If cnt==NDIG before this accept (i.e. the (NDIG+1)th digit), set err[1].
  - Errors are sticky until the frame completes; the frame is not aborted early.
- IDLE->ACC on accept with in_last=0. IDLE->DONE or ACC->DONE on accept with in_last=1.
- Entering DONE, registered, valid in the cycle after the last digit is accepted:
  - out_valid=1.
  - out_bin = err? 0 : final acc.
  - out_ndig = final cnt.
  - out_err = final err flags.
- In DONE:
  - All outputs are held stable while out_ready=0.
  - in_valid is ignored; no digit is consumed.
- DONE with out_ready=1: the result transfers that cycle.
  - Next cycle: out_valid=0, state IDLE, acc/cnt/err cleared, in_ready=1.
  - out_bin/out_ndig/out_err may hold their stale values while out_valid=0.
- Throughput: at most one digit per cycle. Minimum one dead cycle per frame (the DONE cycle).
- in_valid gaps within a frame are permitted; state and acc are held.
- With defaults, the maximum value 9999 fits in 14 bits, so the overflow path is only reachable with a smaller OUT_W.

Test Plan:
1. Reset, then digits 1101, 0100, 1111(last) on consecutive cycles -> next cycle out_valid=1, out_bin=749, out_ndig=3, out_err=00; in_ready=0 until out_ready.
2. Single digit 1011 with in_last, out_ready tied 1 -> out_bin=5, out_ndig=1, out_err=00; out_valid high exactly one cycle; in_ready=1 again the cycle after.
3. Digits 0001, 0110, 0010(last) -> out_bin=0, out_ndig=3, out_err=01; next frame 0010(last) -> out_bin=2, out_err=00 (flag cleared).
4. NDIG=4, digits 1111×5 with in_last on the 5th -> out_bin=0, out_ndig=5, out_err=10. Separately, OUT_W=7 with 0001,0010,1101(last) (127 ok) -> out_bin=127; 0001,0010,1110(last) (128) -> out_err=10, out_bin=0.
5. Backpressure: after frame 0011(last), hold out_ready=0 for 3 cycles while driving in_valid=1 with 0100 -> outputs stable at out_bin=3, in_ready=0, digit not consumed; raise out_ready -> next cycle IDLE and the 0100 is accepted.
6. Gaps and reset: 0010, gap of 2 cycles, 0001, then assert rst for 1 cycle -> no output, all outputs 0; next frame 0011(last) -> out_bin=3, out_ndig=1.
